// File: rtl/y_coord_gen_pkg.sv
// Shared definitions for the vertical-coordinate generator: state encoding,
// default coordinate width and saturation limits at that width.
package y_coord_gen_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int Y_MAX     = (2 ** (WIDTH_DEF - 1)) - 1;
    localparam int Y_MIN     = -(2 ** (WIDTH_DEF - 1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_STEP = 3'd3,
        S_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/y_coord_gen_sat_add.sv
// Combinational signed add with clamp to the WIDTH-bit range and overflow flag.
// Shared with the horizontal-coordinate generator.
module sat_add
    import y_coord_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] wide;

    // Overflow shows up as disagreement between the two top bits of the wide sum.
    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH:0] v);
        if (v[WIDTH] ^ v[WIDTH-1])
            return v[WIDTH] ? S_MIN : S_MAX;
        return v[WIDTH-1:0];
    endfunction

    assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ovf  = wide[WIDTH] ^ wide[WIDTH-1];
    assign sum  = clamp(wide);

endmodule

// File: rtl/y_coord_gen.sv
// Generates the per-row vertical coordinate of one interpolation block
// (Y_INIT, then saturating Y_INIT + k*Y_STEP), paced by ROW_DONE.
module y_coord_gen
    import y_coord_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic                    CLK,
    input  logic                    RST_ASYNC_N,
    input  logic                    START,
    input  logic                    ABORT,
    input  logic signed [WIDTH-1:0] Y_INIT,
    input  logic signed [WIDTH-1:0] Y_STEP,
    input  logic        [CNT_W-1:0] N_ROWS,
    input  logic                    ROW_DONE,
    output logic signed [WIDTH-1:0] Y_OUT,
    output logic                    Y_WE,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    SAT
);

    state_t                  state;
    logic signed [WIDTH-1:0] y_acc;
    logic signed [WIDTH-1:0] y_init_q;
    logic signed [WIDTH-1:0] y_step_q;
    logic        [CNT_W-1:0] n_rows_q;
    logic        [CNT_W-1:0] row_cnt;
    logic signed [WIDTH-1:0] next_y;
    logic                    next_ovf;

    sat_add #(.WIDTH(WIDTH)) u_sat_add (
        .a   (y_acc),
        .b   (y_step_q),
        .sum (next_y),
        .ovf (next_ovf)
    );

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state    <= S_IDLE;
            y_acc    <= '0;
            y_init_q <= '0;
            y_step_q <= '0;
            n_rows_q <= '0;
            row_cnt  <= '0;
            Y_OUT    <= '0;
            Y_WE     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            SAT      <= 1'b0;
        end else if (ABORT) begin
            // Y_OUT and SAT keep their last values so the aborted block can be inspected.
            state <= S_IDLE;
            Y_WE  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            Y_WE <= 1'b0;
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        y_init_q <= Y_INIT;
                        y_step_q <= Y_STEP;
                        n_rows_q <= N_ROWS;
                        SAT      <= 1'b0;
                        BUSY     <= 1'b1;
                        state    <= (N_ROWS == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    Y_OUT   <= y_init_q;
                    y_acc   <= y_init_q;
                    Y_WE    <= 1'b1;
                    row_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // row_cnt holds the index of the row just written.
                    if (ROW_DONE)
                        state <= (row_cnt == n_rows_q - 1'b1) ? S_FIN : S_STEP;
                end
                S_STEP: begin
                    Y_OUT   <= next_y;
                    y_acc   <= next_y;
                    Y_WE    <= 1'b1;
                    row_cnt <= row_cnt + 1'b1;
                    if (next_ovf)
                        SAT <= 1'b1;
                    state   <= S_WAIT;
                end
                S_FIN: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_coord_gen.sv
// Bench for y_coord_gen: cycle-level behavioural model checked every cycle,
// directed blocks with literal expectations, then randomized traffic.
module tb_y_coord_gen;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic signed [7:0] y_init = '0;
    logic signed [7:0] y_step = '0;
    logic        [5:0] n_rows = '0;
    logic              row_done = 1'b0;
    logic signed [7:0] y_out;
    logic              y_we, busy, done, sat;

    int n_checks = 0;
    int n_fail   = 0;

    y_coord_gen #(.WIDTH(8), .CNT_W(6)) dut (
        .CLK         (clk),
        .RST_ASYNC_N (rst_n),
        .START       (start),
        .ABORT       (abort),
        .Y_INIT      (y_init),
        .Y_STEP      (y_step),
        .N_ROWS      (n_rows),
        .ROW_DONE    (row_done),
        .Y_OUT       (y_out),
        .Y_WE        (y_we),
        .BUSY        (busy),
        .DONE        (done),
        .SAT         (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a block is "write due", "waiting for a row", or "finish due".
    int m_y = 0, m_acc = 0, m_init = 0, m_step = 0, m_n = 0, m_k = 0;
    bit m_busy = 0, m_we = 0, m_done = 0, m_sat = 0;
    bit m_wr_due = 0, m_waiting = 0, m_fin_due = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y = 0; m_acc = 0; m_init = 0; m_step = 0; m_n = 0; m_k = 0;
            m_busy = 0; m_we = 0; m_done = 0; m_sat = 0;
            m_wr_due = 0; m_waiting = 0; m_fin_due = 0;
        end else if (abort) begin
            m_busy = 0; m_we = 0; m_done = 0;
            m_wr_due = 0; m_waiting = 0; m_fin_due = 0;
        end else begin
            int v;
            m_we = 0; m_done = 0;
            if (m_fin_due) begin
                m_done = 1; m_busy = 0; m_fin_due = 0;
            end else if (m_wr_due) begin
                v = (m_k == 0) ? m_init : m_acc + m_step;
                if (v > 127)  begin v = 127;  m_sat = 1; end
                if (v < -128) begin v = -128; m_sat = 1; end
                m_y = v; m_acc = v; m_we = 1; m_k++;
                m_wr_due = 0; m_waiting = 1;
            end else if (m_waiting) begin
                if (row_done) begin
                    m_waiting = 0;
                    if (m_k == m_n) m_fin_due = 1; else m_wr_due = 1;
                end
            end else if (!m_busy && start) begin
                m_init = int'(y_init); m_step = int'(y_step); m_n = int'(n_rows);
                m_sat = 0; m_busy = 1; m_k = 0;
                if (m_n == 0) m_fin_due = 1; else m_wr_due = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("y_out", int'(y_out), m_y);
        check("y_we",  int'(y_we),  int'(m_we));
        check("busy",  int'(busy),  int'(m_busy));
        check("done",  int'(done),  int'(m_done));
        check("sat",   int'(sat),   int'(m_sat));
    end

    int got[$];
    int wr_it[$];
    int done_iter;
    int busy_cyc;

    // Runs one block; ROW_DONE follows each write by `gap` cycles, or is held high.
    task automatic run_block(input int init, input int step, input int n, input int gap,
                             input bit hold, input bit glitch, input int abort_after);
        int cnt;
        int abort_it;
        bit fin;
        bit abort_pend;
        got.delete(); wr_it.delete();
        done_iter = -1; busy_cyc = 0; cnt = -1; fin = 0; abort_pend = 0; abort_it = -1;
        @(negedge clk);
        y_init = 8'(init); y_step = 8'(step); n_rows = 6'(n); start = 1'b1; row_done = hold;
        @(negedge clk);
        start = 1'b0;
        y_init = 8'sd55; y_step = 8'sd7; n_rows = 6'd9;
        busy_cyc += int'(busy);
        for (int it = 1; it <= 400 && !fin; it++) begin
            @(negedge clk);
            if (!hold) row_done = 1'b0;
            start = 1'b0;
            abort = 1'b0;
            busy_cyc += int'(busy);
            if (abort_pend) begin
                abort = 1'b1; abort_pend = 0; abort_it = it; cnt = -1;
            end
            if (abort_it > 0 && it == abort_it + 10) fin = 1;
            if (done) begin done_iter = it; fin = 1; end
            if (y_we) begin
                got.push_back(int'(y_out));
                wr_it.push_back(it);
                cnt = gap;
                if (glitch && got.size() == 2) start = 1'b1;
                if (abort_after > 0 && got.size() == abort_after) abort_pend = 1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin row_done = 1'b1; cnt = -1; end
            end
        end
        if (!fin) check("block_timeout", 0, 1);
        @(negedge clk);
        row_done = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_list(input string nm, input int e0, input int e1, input int e2,
                              input int e3, input int cnt);
        int exp[4];
        exp = '{e0, e1, e2, e3};
        check({nm, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt && i < got.size(); i++)
            check($sformatf("%s_w%0d", nm, i), got[i], exp[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check("rst_y_out", int'(y_out), 0);
        check("rst_busy",  int'(busy),  0);
        check("rst_we",    int'(y_we),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_block(-4, 3, 4, 5, 0, 0, 0);
        check_list("basic", -4, -1, 2, 5, 4);
        check("basic_sat", int'(sat), 0);
        check("basic_done_seen", int'(done_iter > 0), 1);

        run_block(-4, 3, 4, 5, 0, 1, 0);
        check_list("glitch", -4, -1, 2, 5, 4);

        run_block(120, 5, 3, 3, 0, 0, 0);
        check_list("possat", 120, 125, 127, 0, 3);
        check("possat_sat", int'(sat), 1);

        run_block(-120, -10, 3, 2, 0, 0, 0);
        check_list("negsat", -120, -128, -128, 0, 3);
        check("negsat_sat", int'(sat), 1);

        run_block(5, 1, 0, 5, 0, 0, 0);
        check("zero_writes", got.size(), 0);
        check("zero_busy_cycles", busy_cyc, 1);
        check("zero_done_iter", done_iter, 1);

        run_block(10, -3, 5, 0, 1, 0, 0);
        check("held_count", got.size(), 5);
        if (got.size() == 5) begin
            check("held_w4", got[4], -2);
            check("held_spacing", wr_it[1] - wr_it[0], 2);
            check("held_spacing_last", wr_it[4] - wr_it[3], 2);
        end

        run_block(0, 10, 5, 5, 0, 0, 2);
        check_list("abort", 0, 10, 0, 0, 2);
        check("abort_no_done", done_iter, -1);
        check("abort_busy", int'(busy), 0);
        check("abort_y_hold", int'(y_out), 10);

        // Asynchronous reset in the middle of a block.
        @(negedge clk);
        y_init = -8'sd4; y_step = 8'sd3; n_rows = 6'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_y_out", int'(y_out), 0);
        check("midrst_we",    int'(y_we),  0);
        check("midrst_busy",  int'(busy),  0);
        check("midrst_done",  int'(done),  0);
        check("midrst_sat",   int'(sat),   0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(-4, 3, 4, 5, 0, 0, 0);
        check_list("postrst", -4, -1, 2, 5, 4);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start    = ($urandom % 6) == 0;
            abort    = ($urandom % 50) == 0;
            row_done = ($urandom % 3) == 0;
            y_init   = 8'($urandom);
            y_step   = ($urandom % 2) ? 8'(int'($urandom_range(0, 40)) - 20) : 8'($urandom);
            n_rows   = 6'($urandom_range(0, 6));
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; row_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
